// File: rtl/fpu_operand_loader.sv
// Byte-serial operand loader for the fused I1*I2 + I3*I4 FPU core: gathers a frame,
// pulses fpu_start, captures the result. Optional macro: FPU_LOADER_GAP_TIMEOUT_EN.
module fpu_operand_loader #(
  parameter int NUM_OPS     = 4,
  parameter int OP_WIDTH    = 32,
  parameter int LATENCY     = 2
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
  ,
  parameter int GAP_TIMEOUT = 255
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic [NUM_OPS*OP_WIDTH-1:0]  ops_out,
  output logic                         fpu_start,
  input  logic [OP_WIDTH-1:0]          fpu_result,
  output logic [OP_WIDTH-1:0]          result_out,
  output logic                         result_valid,
  input  logic                         result_ack,
  output logic                         busy,
  output logic [7:0]                   frames_done
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
  ,
  output logic                         gap_abort
`endif
);

  localparam int NUM_BYTES = NUM_OPS * OP_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              byte_cnt_q, byte_cnt_d;
  logic [LAT_W-1:0]              lat_cnt_q, lat_cnt_d;
  logic [NUM_OPS*OP_WIDTH-1:0]   ops_q, ops_d;
  logic [OP_WIDTH-1:0]           result_q, result_d;
  logic [7:0]                    frames_q, frames_d;

`ifdef FPU_LOADER_GAP_TIMEOUT_EN
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  logic [GAP_W-1:0]              gap_cnt_q, gap_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
      ops_q      <= '0;
      result_q   <= '0;
      frames_q   <= '0;
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      ops_q      <= ops_d;
      result_q   <= result_d;
      frames_q   <= frames_d;
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    ops_d        = ops_q;
    result_d     = result_q;
    frames_d     = frames_q;
    byte_ready   = 1'b0;
    fpu_start    = 1'b0;
    result_valid = 1'b0;
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
    gap_cnt_d    = '0;
    gap_abort    = 1'b0;
`endif
    unique case (state_q)
      S_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          ops_d[8*byte_cnt_q +: 8] = byte_in;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_ISSUE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
        // A stalled partial frame is dropped; stale ops bytes are simply overwritten later.
        else if (byte_cnt_q != '0) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_abort  = 1'b1;
            byte_cnt_d = '0;
          end else begin
            gap_cnt_d  = gap_cnt_q + GAP_W'(1);
          end
        end
`endif
      end
      S_ISSUE: begin
        fpu_start = 1'b1;
        lat_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
        if (lat_cnt_q == LAT_LAST) begin
          result_d  = fpu_result;
          lat_cnt_d = '0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ack) begin
          frames_d = frames_q + 8'd1;
          state_d  = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    busy        = !((state_q == S_LOAD) && (byte_cnt_q == '0));
    ops_out     = ops_q;
    result_out  = result_q;
    frames_done = frames_q;
  end

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader with a fixed-latency FPU stub.
// Define FPU_LOADER_GAP_TIMEOUT_EN to also exercise the gap timeout.
module tb_fpu_operand_loader;

  localparam int NUM_OPS     = 4;
  localparam int OP_WIDTH    = 32;
  localparam int LATENCY     = 2;
  localparam int N           = NUM_OPS * OP_WIDTH / 8;
  localparam int MIN_SPACING = N + LATENCY + 2;

  logic                        clk;
  logic                        rst_n;
  logic [7:0]                  byte_in;
  logic                        byte_valid;
  logic                        byte_ready;
  logic [NUM_OPS*OP_WIDTH-1:0] ops_out;
  logic                        fpu_start;
  logic [OP_WIDTH-1:0]         fpu_result;
  logic [OP_WIDTH-1:0]         result_out;
  logic                        result_valid;
  logic                        result_ack;
  logic                        busy;
  logic [7:0]                  frames_done;
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
  logic                        gap_abort;
  int                          gap_pulses = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int start_count = 0;
  int cyc         = 0;
  int last_start  = -1;
  int min_spacing = 1000000;

  logic [OP_WIDTH-1:0] stub_val = '0;
  logic [LATENCY-1:0]  start_pipe = '0;

  fpu_operand_loader #(
    .NUM_OPS (NUM_OPS),
    .OP_WIDTH(OP_WIDTH),
    .LATENCY (LATENCY)
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
    ,
    .GAP_TIMEOUT(10)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .ops_out     (ops_out),
    .fpu_start   (fpu_start),
    .fpu_result  (fpu_result),
    .result_out  (result_out),
    .result_valid(result_valid),
    .result_ack  (result_ack),
    .busy        (busy),
    .frames_done (frames_done)
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
    ,
    .gap_abort   (gap_abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FPU stub: result is only meaningful exactly LATENCY cycles after fpu_start
  always @(posedge clk) start_pipe <= {start_pipe[LATENCY-2:0], fpu_start};
  assign fpu_result = start_pipe[LATENCY-1] ? stub_val : 32'hDEADBEEF;

  always @(negedge clk) begin
    cyc++;
    if (fpu_start === 1'b1) begin
      start_count++;
      if (last_start >= 0 && (cyc - last_start) < min_spacing) min_spacing = cyc - last_start;
      last_start = cyc;
    end
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
    if (gap_abort === 1'b1) gap_pulses++;
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_byte_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, guard);
    end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [N*8-1:0] frame);
    for (int i = 0; i < N; i++) send_byte(frame[8*i +: 8]);
  endtask

  task automatic wait_result();
    int guard = 0;
    while (result_valid !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_result_timeout: result_valid=%b, required 1", result_valid);
    end
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors += 7;
    if (ops_out !== '0) begin miscompares++; $display("[TB] FAIL reset_ops: got %h, required 0", ops_out); end
    if (result_out !== '0) begin miscompares++; $display("[TB] FAIL reset_result: got %h, required 0", result_out); end
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_result_valid: got %b, required 0", result_valid); end
    if (fpu_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fpu_start: got %b, required 0", fpu_start); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    if (frames_done !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_frames_done: got %0d, required 0", frames_done); end
    if (byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_byte_ready: got %b, required 1", byte_ready); end
  endtask

  task automatic test_basic_frame();
    logic [N*8-1:0] frame = 128'h40800000_3F800000_40400000_40000000;
    int s0 = start_count;
    stub_val = 32'h41200000;
    send_byte(frame[7:0]);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_mid_frame: got %b, required 1", busy); end
    for (int i = 1; i < N; i++) send_byte(frame[8*i +: 8]);
    vectors += 6;
    if (fpu_start !== 1'b1) begin miscompares++; $display("[TB] FAIL start_after_byte16: got %b, required 1", fpu_start); end
    if (start_count != s0) begin miscompares++; $display("[TB] FAIL early_start: got %0d starts, required 0", start_count - s0); end
    if (ops_out[31:0] !== 32'h40000000) begin miscompares++; $display("[TB] FAIL op0: got %h, required 40000000", ops_out[31:0]); end
    if (ops_out[63:32] !== 32'h40400000) begin miscompares++; $display("[TB] FAIL op1: got %h, required 40400000", ops_out[63:32]); end
    if (ops_out[95:64] !== 32'h3F800000) begin miscompares++; $display("[TB] FAIL op2: got %h, required 3F800000", ops_out[95:64]); end
    if (ops_out[127:96] !== 32'h40800000) begin miscompares++; $display("[TB] FAIL op3: got %h, required 40800000", ops_out[127:96]); end
    step();
    vectors += 2;
    if (fpu_start !== 1'b0) begin miscompares++; $display("[TB] FAIL start_pulse_width: got %b, required 0", fpu_start); end
    if (byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_in_wait: got %b, required 0", byte_ready); end
    step();
    vectors++;
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL result_valid_early: got %b, required 0", result_valid); end
    step();
    vectors += 3;
    if (result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL result_valid_latency: got %b, required 1", result_valid); end
    if (result_out !== 32'h41200000) begin miscompares++; $display("[TB] FAIL result_value: got %h, required 41200000", result_out); end
    if (start_count - s0 != 1) begin miscompares++; $display("[TB] FAIL start_count: got %0d, required 1", start_count - s0); end
  endtask

  task automatic test_hold_result();
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    result_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors += 2;
      if (byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready cyc %0d: got %b, required 0", i, byte_ready); end
      if (result_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_valid cyc %0d: got %b, required 1", i, result_valid); end
    end
    byte_valid = 1'b0;
    ack_result();
    vectors += 4;
    if (frames_done !== 8'd1) begin miscompares++; $display("[TB] FAIL ack_frames_done: got %0d, required 1", frames_done); end
    if (byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ack_byte_ready: got %b, required 1", byte_ready); end
    if (result_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_result_valid: got %b, required 0", result_valid); end
    if (ops_out[31:0] !== 32'h40000000) begin miscompares++; $display("[TB] FAIL ops_frozen: got %h, required 40000000", ops_out[31:0]); end
  endtask

  task automatic test_random_valid();
    logic [N*8-1:0] frame = 128'hA7B6C5D4_E3F20110_8899AABB_CCDDEEFF;
    int s0 = start_count;
    int idx = 0;
    int guard = 0;
    logic acc;
    stub_val = 32'h12345678;
    while (idx < N && guard < 500) begin
      byte_in    = frame[8*idx +: 8];
      byte_valid = 1'($urandom_range(0, 1));
      acc        = byte_valid && byte_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    byte_valid = 1'b0;
    vectors += 2;
    if (guard >= 500) begin miscompares++; $display("[TB] FAIL random_timeout: sent %0d bytes, required %0d", idx, N); end
    if (ops_out !== frame) begin miscompares++; $display("[TB] FAIL random_ops: got %h, required %h", ops_out, frame); end
    wait_result();
    vectors += 2;
    if (result_out !== 32'h12345678) begin miscompares++; $display("[TB] FAIL random_result: got %h, required 12345678", result_out); end
    if (start_count - s0 != 1) begin miscompares++; $display("[TB] FAIL random_starts: got %0d, required 1", start_count - s0); end
    ack_result();
    vectors++;
    if (frames_done !== 8'd2) begin miscompares++; $display("[TB] FAIL random_frames_done: got %0d, required 2", frames_done); end
  endtask

  task automatic test_reset_mid_frame();
    logic [N*8-1:0] frame = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    for (int i = 0; i < 7; i++) send_byte(8'hE0 + 8'(i));
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (ops_out !== '0) begin miscompares++; $display("[TB] FAIL midreset_ops: got %h, required 0", ops_out); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy: got %b, required 0", busy); end
    if (frames_done !== 8'd0) begin miscompares++; $display("[TB] FAIL midreset_frames: got %0d, required 0", frames_done); end
    @(negedge clk) rst_n = 1'b1;
    step();
    stub_val = 32'hC0FFEE00;
    send_frame(frame);
    vectors++;
    if (ops_out !== frame) begin miscompares++; $display("[TB] FAIL postreset_ops: got %h, required %h", ops_out, frame); end
    wait_result();
    vectors++;
    if (result_out !== 32'hC0FFEE00) begin miscompares++; $display("[TB] FAIL postreset_result: got %h, required C0FFEE00", result_out); end
    ack_result();
    vectors++;
    if (frames_done !== 8'd1) begin miscompares++; $display("[TB] FAIL postreset_frames: got %0d, required 1", frames_done); end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    for (int f = 0; f < 256; f++) begin
      stub_val = 32'(f);
      send_frame({N{8'(f)}});
      wait_result();
      if (f == 255) begin
        vectors++;
        if (result_out !== 32'd255) begin miscompares++; $display("[TB] FAIL wrap_last_result: got %h, required ff", result_out); end
      end
      ack_result();
      if (f == 254) begin
        vectors++;
        if (frames_done !== 8'd255) begin miscompares++; $display("[TB] FAIL wrap_255: got %0d, required 255", frames_done); end
      end
    end
    vectors++;
    if (frames_done !== 8'd0) begin miscompares++; $display("[TB] FAIL wrap_0: got %0d, required 0", frames_done); end
  endtask

`ifdef FPU_LOADER_GAP_TIMEOUT_EN
  task automatic test_gap_timeout();
    logic [N*8-1:0] frame = 128'h11223344_55667788_99AABBCC_DDEEFF01;
    int p0 = gap_pulses;
    for (int i = 0; i < 5; i++) send_byte(8'h55);
    repeat (10) step();
    vectors += 2;
    if (gap_pulses - p0 != 1) begin miscompares++; $display("[TB] FAIL gap_pulse: got %0d pulses, required 1", gap_pulses - p0); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_busy: got %b, required 0", busy); end
    repeat (5) step();
    vectors++;
    if (gap_pulses - p0 != 1) begin miscompares++; $display("[TB] FAIL gap_single: got %0d pulses, required 1", gap_pulses - p0); end
    stub_val = 32'hABCD0123;
    send_frame(frame);
    vectors++;
    if (ops_out !== frame) begin miscompares++; $display("[TB] FAIL gap_reload_ops: got %h, required %h", ops_out, frame); end
    wait_result();
    vectors++;
    if (result_out !== 32'hABCD0123) begin miscompares++; $display("[TB] FAIL gap_result: got %h, required ABCD0123", result_out); end
    ack_result();
  endtask
`endif

  task automatic test_start_spacing();
    vectors++;
    if (min_spacing < MIN_SPACING) begin
      miscompares++;
      $display("[TB] FAIL start_spacing: got %0d cycles, required >= %0d", min_spacing, MIN_SPACING);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    byte_in    = '0;
    byte_valid = 1'b0;
    result_ack = 1'b0;
    test_reset();
    test_basic_frame();
    test_hold_result();
    test_random_valid();
    test_reset_mid_frame();
    test_frame_wrap();
`ifdef FPU_LOADER_GAP_TIMEOUT_EN
    test_gap_timeout();
`endif
    test_start_spacing();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
